// File: rtl/arb_target_pkg.sv
// Shared definitions for arb_target: 2-bit state encoding and default parameters.
package arb_target_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      ACK   = 2'd2,
      GAP   = 2'd3
   } state_e;

   localparam int DEF_SVC_CYCLES = 4;
   localparam int DEF_CNT_W      = 8;
   localparam int SVC_CNT_W      = 8;

endpackage

// File: rtl/arb_target.sv
// Service target behind a static arbiter: serves a request for SVC_CYCLES cycles,
// then acks once. Optional macro ARB_TARGET_STALL_EN adds a stall input for SERVE.
module arb_target
   import arb_target_pkg::*;
#(
   parameter int SVC_CYCLES = DEF_SVC_CYCLES,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
`ifdef ARB_TARGET_STALL_EN
   input  logic             stall,
`endif
   output logic             ack,
   output logic             busy,
   output logic             abort,
   output logic [CNT_W-1:0] done_cnt
);

   localparam logic [SVC_CNT_W-1:0] SVC_LAST = SVC_CNT_W'(SVC_CYCLES - 1);

   state_e                 state_q, state_d;
   logic [SVC_CNT_W-1:0]   svc_cnt_q, svc_cnt_d;
   logic [CNT_W-1:0]       done_q, done_d;
   logic                   ack_q, ack_d;
   logic                   busy_q, busy_d;
   logic                   abort_q, abort_d;
   logic                   stall_w;

`ifdef ARB_TARGET_STALL_EN
   assign stall_w = stall;
`else
   assign stall_w = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      svc_cnt_d = svc_cnt_q;
      done_d    = done_q;
      abort_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d   = SERVE;
               svc_cnt_d = '0;
            end
         end
         SERVE: begin
            // A dropped request wins over stall: the service is abandoned.
            if (!req) begin
               state_d = IDLE;
               abort_d = 1'b1;
            end else if (!stall_w) begin
               if (svc_cnt_q == SVC_LAST) begin
                  state_d = ACK;
               end else begin
                  svc_cnt_d = svc_cnt_q + 8'd1;
               end
            end
         end
         ACK: begin
            state_d = GAP;
            if (req) begin
               done_d = done_q + CNT_W'(1);
            end
         end
         GAP: begin
            if (req) begin
               state_d   = SERVE;
               svc_cnt_d = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      ack_d  = (state_d == ACK);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         svc_cnt_q <= '0;
         done_q    <= '0;
         ack_q     <= 1'b0;
         busy_q    <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         svc_cnt_q <= svc_cnt_d;
         done_q    <= done_d;
         ack_q     <= ack_d;
         busy_q    <= busy_d;
         abort_q   <= abort_d;
      end
   end

   assign ack      = ack_q;
   assign busy     = busy_q;
   assign abort    = abort_q;
   assign done_cnt = done_q;

endmodule

// File: tb/tb_arb_target.sv
// Self-checking bench for arb_target: directed scenarios plus random traffic against
// a cycle-position reference model (two instances: SVC=4/CNT_W=8 and SVC=1/CNT_W=2).
module tb_arb_target;

   logic clk = 1'b0;
   logic rst, req, stall;
   always #5 clk = ~clk;

   logic       ack_a, busy_a, abort_a;
   logic [7:0] done_a;
   logic       ack_b, busy_b, abort_b;
   logic [1:0] done_b;

`ifdef ARB_TARGET_STALL_EN
   localparam bit HAS_STALL = 1'b1;
`else
   localparam bit HAS_STALL = 1'b0;
`endif

   arb_target #(.SVC_CYCLES(4), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .req(req),
`ifdef ARB_TARGET_STALL_EN
      .stall(stall),
`endif
      .ack(ack_a), .busy(busy_a), .abort(abort_a), .done_cnt(done_a)
   );

   arb_target #(.SVC_CYCLES(1), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .req(req),
`ifdef ARB_TARGET_STALL_EN
      .stall(stall),
`endif
      .ack(ack_b), .busy(busy_b), .abort(abort_b), .done_cnt(done_b)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc_no   = 0;

   // Model: position within the current attempt; -1 idle, 0..S-1 serving, S ack, S+1 gap.
   int t_m[2];
   int done_m[2];
   bit abort_m[2];
   int svc_m[2] = '{4, 1};
   int mod_m[2] = '{256, 4};
   bit prev_ack_a, prev_ack_b;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         t_m[i] = -1; done_m[i] = 0; abort_m[i] = 1'b0;
      end
   endfunction

   function automatic void model_step(input bit r, input bit st);
      bit st_eff;
      st_eff = HAS_STALL && st;
      for (int i = 0; i < 2; i++) begin
         abort_m[i] = 1'b0;
         if (t_m[i] == -1) begin
            if (r) t_m[i] = 0;
         end else if (t_m[i] < svc_m[i]) begin
            if (!r) begin
               t_m[i] = -1; abort_m[i] = 1'b1;
            end else if (!st_eff) begin
               t_m[i] = t_m[i] + 1;
            end
         end else if (t_m[i] == svc_m[i]) begin
            if (r) done_m[i] = (done_m[i] + 1) % mod_m[i];
            t_m[i] = svc_m[i] + 1;
         end else begin
            t_m[i] = r ? 0 : -1;
         end
      end
   endfunction

   task automatic check_all(input string tag);
      $display("cyc %0d %s rst=%b req=%b stall=%b | A ack=%b busy=%b abort=%b done=%0d | B ack=%b busy=%b abort=%b done=%0d",
               cyc_no, tag, rst, req, stall, ack_a, busy_a, abort_a, done_a, ack_b, busy_b, abort_b, done_b);
      chk({tag, "_a_ack"},   ack_a,   (t_m[0] == svc_m[0]));
      chk({tag, "_a_busy"},  busy_a,  (t_m[0] != -1));
      chk({tag, "_a_abort"}, abort_a, abort_m[0]);
      chk({tag, "_a_done"},  done_a,  done_m[0]);
      chk({tag, "_b_ack"},   ack_b,   (t_m[1] == svc_m[1]));
      chk({tag, "_b_busy"},  busy_b,  (t_m[1] != -1));
      chk({tag, "_b_abort"}, abort_b, abort_m[1]);
      chk({tag, "_b_done"},  done_b,  done_m[1]);
      chk({tag, "_a_ack_twice"}, ack_a & prev_ack_a, 0);
      chk({tag, "_b_ack_twice"}, ack_b & prev_ack_b, 0);
      prev_ack_a = ack_a;
      prev_ack_b = ack_b;
   endtask

   // Called just after a falling edge; applies inputs, steps model at the rising edge.
   task automatic cyc(input bit r, input bit st, input string tag);
      req = r; stall = st;
      @(posedge clk);
      model_step(r, st);
      cyc_no++;
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      model_reset();
      check_all({tag, "_async"});
      chk({tag, "_busy_now"}, busy_a, 0);
      chk({tag, "_done_now"}, done_a, 0);
      @(posedge clk);
      @(negedge clk);
      check_all({tag, "_hold"});
      rst = 1'b0;
      prev_ack_a = 1'b0;
      prev_ack_b = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; stall = 1'b0;
      prev_ack_a = 1'b0; prev_ack_b = 1'b0;
      model_reset();
      @(negedge clk);
      do_reset("init");

      // Back-to-back with req held high: acks after edges 4 and 10 only.
      for (int k = 0; k < 12; k++) begin
         cyc(1'b1, 1'b0, "b2b");
         chk("b2b_ack_lit", ack_a, (k == 4 || k == 10));
      end
      chk("b2b_done2", done_a, 2);

      // Request dropped mid-SERVE: one abort pulse, nothing completed.
      do_reset("r1");
      for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, "abt");
      cyc(1'b0, 1'b0, "abt");
      chk("abt_pulse", abort_a, 1);
      chk("abt_busy", busy_a, 0);
      chk("abt_done", done_a, 0);
      cyc(1'b0, 1'b0, "abt");
      chk("abt_once", abort_a, 0);

      // Request dropped exactly in the ACK cycle.
      do_reset("r2");
      for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, "ackdrop");
      chk("ackdrop_ack", ack_a, 1);
      cyc(1'b0, 1'b0, "ackdrop");
      chk("ackdrop_done", done_a, 0);
      chk("ackdrop_noabort", abort_a, 0);
      chk("ackdrop_gap", busy_a, 1);
      cyc(1'b0, 1'b0, "ackdrop");
      chk("ackdrop_idle", busy_a, 0);

      // Reset in the middle of SERVE.
      do_reset("r3");
      for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, "midsrv");
      do_reset("midsrv_rst");
      chk("midsrv_abort", abort_a, 0);
      cyc(1'b1, 1'b0, "midsrv_restart");
      chk("midsrv_restart_busy", busy_a, 1);

      // 2-bit counter with SVC_CYCLES=1: completions every 3 cycles, wrapping.
      do_reset("r4");
      for (int k = 0; k < 15; k++) begin
         cyc(1'b1, 1'b0, "wrap");
         chk("wrap_seq", done_b, ((k + 1) / 3) % 4);
      end

`ifdef ARB_TARGET_STALL_EN
      // Three stalled SERVE cycles push the ack from edge 4 to edge 7.
      do_reset("r5");
      for (int k = 0; k < 10; k++) begin
         cyc(1'b1, (k >= 2 && k <= 4), "stall");
         chk("stall_ack", ack_a, (k == 7));
      end
`endif

      // Random traffic with occasional asynchronous resets.
      do_reset("r6");
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 59) == 0) begin
            do_reset("rnd_rst");
         end else begin
            cyc(($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 20), "rnd");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
